// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//   Direct-mapped dynamic branch predictor: a 2-bit saturating counter table
//   (BHT) combined with a tagged branch target buffer (BTB). The IF stage looks
//   up a prediction combinationally. The EX stage writes back the resolved
//   outcome, which takes effect at the next rising edge.
//
//   Optional feature macro: BP_STATS_EN
//     defined   -> saturating resolved-branch / mispredict counters are built
//     undefined -> stat_* outputs are tied to 0 and no counter flops exist
//
// Parameters
//   ENTRIES  number of BHT/BTB entries (power of two, 4..256)
//   XLEN     PC / target width
//
// Ports
//   clk               core clock, all state updates on the rising edge
//   reset             asynchronous, active-low reset
//   lookup_pc         PC of the instruction in IF
//   pred_taken        predicted direction (branch_prediction downstream)
//   pred_target       predicted next PC
//   pred_hit          BTB tag match for lookup_pc
//   upd_valid         EX resolves a conditional branch this cycle
//   upd_pc            PC of the resolved branch
//   upd_taken         actual outcome
//   upd_target        actual taken target
//   upd_pred_taken    direction that was predicted for this branch
//   upd_pred_target   target that was predicted for this branch
//   stat_branches     resolved-branch count
//   stat_mispredicts  mispredict count
// -----------------------------------------------------------------------------
module branch_predictor #(
    parameter int ENTRIES = 64,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    output logic            pred_hit,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_pred_taken,
    input  logic [XLEN-1:0] upd_pred_target,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
);

    localparam int IDX = $clog2(ENTRIES);
    localparam int TW  = XLEN - IDX - 2;

    logic [1:0]      ctr_q    [ENTRIES];
    logic [1:0]      ctr_d    [ENTRIES];
    logic            valid_q  [ENTRIES];
    logic            valid_d  [ENTRIES];
    logic [TW-1:0]   tag_q    [ENTRIES];
    logic [TW-1:0]   tag_d    [ENTRIES];
    logic [XLEN-1:0] target_q [ENTRIES];
    logic [XLEN-1:0] target_d [ENTRIES];

    logic [IDX-1:0]  l_idx;
    logic [TW-1:0]   l_tag;
    logic [IDX-1:0]  u_idx;
    logic [TW-1:0]   u_tag;
    logic            u_match;
    logic [1:0]      u_base;

    assign l_idx = lookup_pc[IDX+1:2];
    assign l_tag = lookup_pc[XLEN-1:IDX+2];
    assign u_idx = upd_pc[IDX+1:2];
    assign u_tag = upd_pc[XLEN-1:IDX+2];

    // Lookup reads pre-update state only: a same-cycle update to the same
    // index is not bypassed.
    always_comb begin
        pred_hit    = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
        pred_taken  = pred_hit && ctr_q[l_idx][1];
        pred_target = pred_taken ? target_q[l_idx] : lookup_pc + XLEN'(4);
    end

    // A taken branch that misses reallocates the entry from a weakly
    // not-taken base; a not-taken branch that misses leaves the entry alone.
    always_comb begin
        ctr_d    = ctr_q;
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        u_match  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        u_base   = u_match ? ctr_q[u_idx] : 2'b01;
        if (upd_valid) begin
            if (upd_taken) begin
                ctr_d[u_idx]    = (u_base == 2'b11) ? 2'b11 : u_base + 2'd1;
                valid_d[u_idx]  = 1'b1;
                tag_d[u_idx]    = u_tag;
                target_d[u_idx] = upd_target;
            end else if (u_match) begin
                ctr_d[u_idx]    = (u_base == 2'b00) ? 2'b00 : u_base - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i]    <= 2'b01;
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
            end
        end else begin
            ctr_q    <= ctr_d;
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] br_q, br_d;
    logic [31:0] mis_q, mis_d;
    logic        mispredict;

    assign mispredict = (upd_pred_taken != upd_taken) ||
                        (upd_taken && (upd_pred_target != upd_target));

    always_comb begin
        br_d  = br_q;
        mis_d = mis_q;
        if (upd_valid) begin
            if (br_q != 32'hFFFF_FFFF) br_d = br_q + 32'd1;
            if (mispredict && (mis_q != 32'hFFFF_FFFF)) mis_d = mis_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            br_q  <= '0;
            mis_q <= '0;
        end else begin
            br_q  <= br_d;
            mis_q <= mis_d;
        end
    end

    assign stat_branches    = br_q;
    assign stat_mispredicts = mis_q;

    logic unused_lsb;
    assign unused_lsb = ^{lookup_pc[1:0], upd_pc[1:0]};
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;

    // Predicted direction/target only feed the statistics.
    logic unused_lsb;
    assign unused_lsb = ^{lookup_pc[1:0], upd_pc[1:0], upd_pred_taken, upd_pred_target};
`endif

endmodule
